hififo_tpc_write_engine: RTL

- To-PC (FPGA→host) DMA engine; the transmit-side counterpart of the from-PC FIFO path.
- Accepts host-programmed descriptors (length word, then address/start word) and stages user FIFO data in 128-byte blocks (16 qwords).
- Emits each block as one memory-write burst toward the PCIe TX arbiter.
- Maintains a running block counter, a match interrupt and a descriptor-done interrupt.

---
 rtl/hififo_tpc_write_engine.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hififo_tpc_write_engine.sv
// To-PC DMA write engine: takes host descriptors (length, then address),
// gathers user FIFO data into 128-byte blocks and emits each block as one
// 16-qword memory-write burst. Tracks completed blocks and raises a match
// interrupt and a descriptor-done interrupt.
module hififo_tpc_write_engine #(
  parameter int DESC_DEPTH = 4,
  parameter int COUNT_BITS = 23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        desc_valid,
  input  logic [63:0] desc_data,
  output logic        desc_ready,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [63:0] wr_addr,
  output logic [63:0] wr_data,
  output logic        wr_last,
  output logic [31:0] status,
  output logic [1:0]  interrupt
);
  localparam int PW = $clog2(DESC_DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, BURST} state_t;
  state_t state, state_nxt;

  // Descriptor queue entry: {block address [56:0], block count [15:0]}
  logic [72:0]           q_mem [DESC_DEPTH];
  logic [PW:0]           q_wr, q_rd;
  logic [72:0]           q_head;
  logic                  queue_empty, queue_full, q_push, q_pop;

  logic                  desc_fire;
  logic [2:0]            desc_type;
  logic [15:0]           pending_len;
  logic [56:0]           addr;
  logic [15:0]           remaining;
  logic [3:0]            fill_idx, emit_idx;
  logic [63:0]           blk_buf [16];
  logic [COUNT_BITS-1:0] blocks_done, matchval;
  logic [22:0]           blocks_st;
  logic                  armed, match_hit;
  logic                  in_fire, wr_fire, burst_done, last_block, done_evt;
  logic                  int_match, int_done;

  assign desc_fire   = desc_valid & desc_ready;
  assign desc_type   = desc_data[2:0];
  assign desc_ready  = ~queue_full;
  assign queue_empty = (q_wr == q_rd);
  assign queue_full  = (q_wr[PW] != q_rd[PW]) && (q_wr[PW-1:0] == q_rd[PW-1:0]);
  assign q_head      = q_mem[q_rd[PW-1:0]];
  assign q_push      = desc_fire && (desc_type == 3'd2);
  assign q_pop       = (state == IDLE) && !queue_empty;

  assign in_fire     = in_valid & in_ready;
  assign wr_fire     = wr_valid & wr_ready;
  assign burst_done  = wr_fire && (emit_idx == 4'd15);
  assign last_block  = (remaining == 16'd1);
  // A zero-length descriptor completes the moment it is popped.
  assign done_evt    = (q_pop && (q_head[15:0] == 16'd0)) || (burst_done && last_block);
  assign match_hit   = armed && (blocks_done == matchval);

  assign blocks_st   = 23'(blocks_done);
  assign status      = {blocks_st, 7'd0, (state != IDLE), queue_empty};
  assign interrupt   = {int_done, int_match};

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (q_pop && (q_head[15:0] != 16'd0)) state_nxt = FILL;
      FILL:    if (in_fire && (fill_idx == 4'd15)) state_nxt = BURST;
      BURST:   if (burst_done) state_nxt = last_block ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: data accepted only in FILL, burst presented only in BURST
  always_comb begin
    in_ready = (state == FILL);
    wr_valid = (state == BURST);
    wr_last  = (state == BURST) && (emit_idx == 4'd15);
    wr_data  = blk_buf[emit_idx];
    wr_addr  = {addr, 7'd0};
  end

  // Queue pointers; push and pop may both happen in one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_wr <= '0;
      q_rd <= '0;
    end else begin
      if (q_push) q_wr <= q_wr + 1'b1;
      if (q_pop)  q_rd <= q_rd + 1'b1;
    end
  end

  // Queue storage (data only, no reset)
  always_ff @(posedge clock) begin
    if (q_push) q_mem[q_wr[PW-1:0]] <= {desc_data[63:7], pending_len};
  end

  // Block staging buffer (data only, no reset)
  always_ff @(posedge clock) begin
    if (in_fire) blk_buf[fill_idx] <= in_data;
  end

  // Transfer bookkeeping: current descriptor, fill/emit indices, block counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_len <= '0;
      addr        <= '0;
      remaining   <= '0;
      fill_idx    <= '0;
      emit_idx    <= '0;
      blocks_done <= '0;
    end else begin
      if (desc_fire && (desc_type == 3'd1)) pending_len <= desc_data[22:7];
      if (q_pop) begin
        addr      <= q_head[72:16];
        remaining <= q_head[15:0];
      end
      if (in_fire) fill_idx <= fill_idx + 4'd1;
      if (wr_fire) emit_idx <= emit_idx + 4'd1;
      if (burst_done) begin
        addr        <= addr + 57'd1;
        remaining   <= remaining - 16'd1;
        blocks_done <= blocks_done + COUNT_BITS'(1);
        fill_idx    <= '0;
        emit_idx    <= '0;
      end
    end
  end

  // Match arming and registered interrupt pulses; a new type-3 write beats the auto-disarm
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      matchval  <= '0;
      armed     <= 1'b0;
      int_match <= 1'b0;
      int_done  <= 1'b0;
    end else begin
      if (desc_fire && (desc_type == 3'd3)) begin
        matchval <= COUNT_BITS'(desc_data[29:7]);
        armed    <= 1'b1;
      end else if (match_hit) begin
        armed    <= 1'b0;
      end
      int_match <= match_hit;
      int_done  <= done_evt;
    end
  end

endmodule
